// File: rtl/cam_srl_learn_if.sv
// Bus bundle for the learning CAM: lookup, learn, delete and aging signals.
interface cam_srl_learn_if #(
  parameter int DATA_WIDTH = 48,
  parameter int ADDR_WIDTH = 5
);
  logic [DATA_WIDTH-1:0] compare_data;
  logic                  compare_valid;
  logic                  compare_ready;
  logic                  match_valid;
  logic                  match;
  logic [ADDR_WIDTH-1:0] match_addr;
  logic [DATA_WIDTH-1:0] learn_data;
  logic                  learn_valid;
  logic                  learn_ready;
  logic                  learn_done;
  logic [ADDR_WIDTH-1:0] learn_addr;
  logic [1:0]            learn_status;
  logic [ADDR_WIDTH-1:0] delete_addr;
  logic                  delete_valid;
  logic                  age_tick;
  logic [ADDR_WIDTH:0]   entry_count;

  modport master (
    output compare_data, compare_valid, learn_data, learn_valid,
           delete_addr, delete_valid, age_tick,
    input  compare_ready, match_valid, match, match_addr, learn_ready,
           learn_done, learn_addr, learn_status, entry_count
  );

  modport slave (
    input  compare_data, compare_valid, learn_data, learn_valid,
           delete_addr, delete_valid, age_tick,
    output compare_ready, match_valid, match, match_addr, learn_ready,
           learn_done, learn_addr, learn_status, entry_count
  );
endinterface

// File: rtl/cam_srl_learn.sv
// Learning CAM: SRL-sliced key store with per-entry valid/age, a learn FSM
// that allocates free slots or evicts the oldest entry, delete and aging.
module cam_srl_learn #(
  parameter int DATA_WIDTH  = 48,
  parameter int ADDR_WIDTH  = 5,
  parameter int SLICE_WIDTH = 4,
  parameter int AGE_WIDTH   = 3
) (
  input logic            clk,
  input logic            rst,
  cam_srl_learn_if.slave bus
);
  localparam int N     = 2**ADDR_WIDTH;
  localparam int W     = 2**SLICE_WIDTH;
  localparam int NS    = (DATA_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH;
  localparam int KEY_W = NS * SLICE_WIDTH;
  localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

  typedef enum logic [2:0] {IDLE, PROBE, WAIT0, WAIT1, WRITE, DONE} state_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  state_t                      state_q, state_d;
  logic [N-1:0]                valid_q, valid_d;
  logic [N-1:0][AGE_WIDTH-1:0] age_q, age_d;
  logic [N-1:0][NS-1:0][W-1:0] srl_q, srl_d;
  logic [KEY_W-1:0]            lkey_q, lkey_d;    // learn key, held for probe and write
  addr_t                       tgt_q, tgt_d;
  logic [1:0]                  status_q, status_d;
  logic                        kill_q, kill_d;    // target deleted while being written
  logic [SLICE_WIDTH-1:0]      wcnt_q, wcnt_d;
  logic [ADDR_WIDTH:0]         count_q, count_d;
  logic [1:0]                  vld_pipe_q, vld_pipe_d;
  logic [1:0]                  prb_pipe_q, prb_pipe_d;
  logic [KEY_W-1:0]            s1_key_q, s1_key_d;
  logic                        m_hit_q, m_hit_d;
  addr_t                       m_addr_q, m_addr_d;

  function automatic logic [KEY_W-1:0] pad(input logic [DATA_WIDTH-1:0] k);
    pad = '0;
    pad[DATA_WIDTH-1:0] = k;
  endfunction

  // Each SRL slice holds a one-hot-per-value match bit; AND slices, mask by valid.
  logic [N-1:0] hit;
  for (genvar e = 0; e < N; e++) begin : g_ent
    logic [NS-1:0] raw;
    for (genvar s = 0; s < NS; s++) begin : g_sl
      assign raw[s] = srl_q[e][s][s1_key_q[s*SLICE_WIDTH +: SLICE_WIDTH]];
    end
    assign hit[e] = (&raw) & valid_q[e];
  end

  addr_t                hit_addr, free_addr, old_addr;
  logic                 any_hit, any_free;
  logic [AGE_WIDTH-1:0] old_age;

  // Lowest hit, lowest free slot, and oldest valid entry (lowest index on tie).
  always_comb begin
    hit_addr  = '0;
    free_addr = '0;
    old_addr  = '0;
    any_hit   = 1'b0;
    any_free  = 1'b0;
    old_age   = '0;
    for (int e = N-1; e >= 0; e--) begin
      if (hit[e]) begin
        any_hit  = 1'b1;
        hit_addr = addr_t'(e);
      end
      if (!valid_q[e]) begin
        any_free  = 1'b1;
        free_addr = addr_t'(e);
      end
      if (valid_q[e] && age_q[e] >= old_age) begin
        old_age  = age_q[e];
        old_addr = addr_t'(e);
      end
    end
  end

  // Lookup pipeline: the FSM probe takes the slot in PROBE, else external requests.
  always_comb begin
    vld_pipe_d = {vld_pipe_q[0], 1'b0};
    prb_pipe_d = {prb_pipe_q[0], 1'b0};
    s1_key_d   = s1_key_q;
    m_hit_d    = m_hit_q;
    m_addr_d   = m_addr_q;
    if (state_q == PROBE) begin
      vld_pipe_d[0] = 1'b1;
      prb_pipe_d[0] = 1'b1;
      s1_key_d      = lkey_q;
    end else if (bus.compare_valid) begin
      vld_pipe_d[0] = 1'b1;
      s1_key_d      = pad(bus.compare_data);
    end
    if (vld_pipe_q[0]) begin
      m_hit_d  = any_hit;
      m_addr_d = hit_addr;
    end
  end

  // Learn FSM: probe, decide hit/free/evict at end of WAIT, shift key into SRLs.
  always_comb begin
    state_d  = state_q;
    lkey_d   = lkey_q;
    tgt_d    = tgt_q;
    status_d = status_q;
    kill_d   = kill_q;
    wcnt_d   = wcnt_q;
    srl_d    = srl_q;
    case (state_q)
      IDLE: if (bus.learn_valid) begin
        lkey_d  = pad(bus.learn_data);
        state_d = PROBE;
      end
      PROBE: state_d = WAIT0;
      WAIT0: state_d = WAIT1;
      WAIT1: begin
        kill_d = 1'b0;
        wcnt_d = '0;
        if (m_hit_q) begin
          tgt_d    = m_addr_q;
          status_d = 2'd1;
          state_d  = DONE;
        end else if (any_free) begin
          tgt_d    = free_addr;
          status_d = 2'd0;
          state_d  = WRITE;
        end else begin
          tgt_d    = old_addr;
          status_d = 2'd2;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        // Cycle k shifts in (slice == W-1-k); after W shifts bit v means "slice == v".
        for (int s = 0; s < NS; s++)
          srl_d[tgt_q][s] = {srl_q[tgt_q][s][W-2:0],
                             lkey_q[s*SLICE_WIDTH +: SLICE_WIDTH] == ~wcnt_q};
        wcnt_d = wcnt_q + 1'b1;
        if (&wcnt_q) state_d = DONE;
        if (bus.delete_valid && bus.delete_addr == tgt_q) kill_d = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-entry valid/age: delete/write-clear > DONE-set/refresh > age tick.
  always_comb begin
    valid_d = valid_q;
    age_d   = age_q;
    count_d = '0;
    for (int e = 0; e < N; e++) begin
      if ((bus.delete_valid && bus.delete_addr == addr_t'(e)) ||
          (state_q == WRITE && wcnt_q == '0 && tgt_q == addr_t'(e))) begin
        valid_d[e] = 1'b0;
      end else if (state_q == DONE && tgt_q == addr_t'(e)) begin
        if (!kill_q) begin
          valid_d[e] = 1'b1;
          age_d[e]   = '0;
        end
      end else if (vld_pipe_q[1] && m_hit_q && m_addr_q == addr_t'(e)) begin
        age_d[e] = '0;
      end else if (bus.age_tick && valid_q[e]) begin
        if (age_q[e] == AGE_MAX) valid_d[e] = 1'b0;
        else                     age_d[e]   = age_q[e] + 1'b1;
      end
      count_d = count_d + {{ADDR_WIDTH{1'b0}}, valid_d[e]};
    end
  end

  // Control and table state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      age_q      <= '0;
      lkey_q     <= '0;
      tgt_q      <= '0;
      status_q   <= '0;
      kill_q     <= 1'b0;
      wcnt_q     <= '0;
      count_q    <= '0;
      vld_pipe_q <= '0;
      prb_pipe_q <= '0;
      s1_key_q   <= '0;
      m_hit_q    <= 1'b0;
      m_addr_q   <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      age_q      <= age_d;
      lkey_q     <= lkey_d;
      tgt_q      <= tgt_d;
      status_q   <= status_d;
      kill_q     <= kill_d;
      wcnt_q     <= wcnt_d;
      count_q    <= count_d;
      vld_pipe_q <= vld_pipe_d;
      prb_pipe_q <= prb_pipe_d;
      s1_key_q   <= s1_key_d;
      m_hit_q    <= m_hit_d;
      m_addr_q   <= m_addr_d;
    end
  end

  // SRL contents carry no reset; stale keys are masked by valid.
  always_ff @(posedge clk) begin
    srl_q <= srl_d;
  end

  assign bus.compare_ready = rst | (state_q != PROBE);
  assign bus.match_valid   = vld_pipe_q[1] & ~prb_pipe_q[1];
  assign bus.match         = m_hit_q;
  assign bus.match_addr    = m_addr_q;
  assign bus.learn_ready   = (state_q == IDLE) & ~rst;
  assign bus.learn_done    = (state_q == DONE);
  assign bus.learn_addr    = tgt_q;
  assign bus.learn_status  = status_q;
  assign bus.entry_count   = count_q;
endmodule

// File: tb/tb_cam_srl_learn.sv
// Directed bench for cam_srl_learn: expected lookup/learn results queued at
// drive time with their due cycle, popped and compared by a monitor.
`timescale 1ns/1ps
module tb_cam_srl_learn;
  localparam int DW = 48, AW = 5, SW = 4, AGW = 3, W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cam_srl_learn_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  cam_srl_learn #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLICE_WIDTH(SW), .AGE_WIDTH(AGW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int at; logic hit; logic [AW-1:0] addr; } mexp_t;
  typedef struct { int at; logic [AW-1:0] addr; logic [1:0] st; } lexp_t;
  mexp_t mq[$];
  lexp_t lq[$];

  localparam logic [DW-1:0] K0 = 48'h001122334455;
  localparam logic [DW-1:0] KN = 48'hFFFFFFFFFFF0;
  localparam logic [DW-1:0] KX = 48'h5A5A5A5A5A5A;
  localparam logic [DW-1:0] KA = 48'h0A0B0C0D0E0F;
  localparam logic [DW-1:0] KB = 48'hF0E0D0C0B0A0;

  function automatic logic [DW-1:0] key(input int i);
    key = 48'h0000ABCD0000 | 48'(i);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: compare result strobes against the queued expectations.
  always @(negedge clk) begin
    mexp_t m;
    lexp_t l;
    if (mq.size() != 0 && mq[0].at < cyc) begin
      m = mq.pop_front();
      check("match_missing_at", 64'(cyc), 64'(m.at));
    end
    if (lq.size() != 0 && lq[0].at < cyc) begin
      l = lq.pop_front();
      check("learn_missing_at", 64'(cyc), 64'(l.at));
    end
    if (bus.match_valid === 1'b1) begin
      if (mq.size() == 0) check("unexpected_match_valid", 64'(bus.match_valid), 64'(0));
      else begin
        m = mq.pop_front();
        check("match_cycle", 64'(cyc), 64'(m.at));
        check("match", 64'(bus.match), 64'(m.hit));
        check("match_addr", 64'(bus.match_addr), 64'(m.addr));
      end
    end
    if (bus.learn_done === 1'b1) begin
      if (lq.size() == 0) check("unexpected_learn_done", 64'(bus.learn_done), 64'(0));
      else begin
        l = lq.pop_front();
        check("learn_cycle", 64'(cyc), 64'(l.at));
        check("learn_addr", 64'(bus.learn_addr), 64'(l.addr));
        check("learn_status", 64'(bus.learn_status), 64'(l.st));
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lookup(input logic [DW-1:0] k, input logic hit, input logic [AW-1:0] a);
    mexp_t m;
    m.at = cyc + 2; m.hit = hit; m.addr = a;
    mq.push_back(m);
    bus.compare_data  = k;
    bus.compare_valid = 1'b1;
    step();
    bus.compare_valid = 1'b0;
  endtask

  task automatic learn(input logic [DW-1:0] k, input logic [AW-1:0] a, input logic [1:0] st);
    lexp_t l;
    check("learn_ready_at_req", 64'(bus.learn_ready), 64'(1));
    l.at = cyc + ((st == 2'd1) ? 4 : 4 + W); l.addr = a; l.st = st;
    lq.push_back(l);
    bus.learn_data  = k;
    bus.learn_valid = 1'b1;
    step();
    bus.learn_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((mq.size() != 0 || lq.size() != 0) && n < 64) begin
      step();
      n++;
    end
    if (n >= 64) check("drain_timeout", 64'(mq.size() + lq.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.compare_data  = '0;
    bus.compare_valid = 1'b0;
    bus.learn_data    = '0;
    bus.learn_valid   = 1'b0;
    bus.delete_addr   = '0;
    bus.delete_valid  = 1'b0;
    bus.age_tick      = 1'b0;

    // Reset state
    step(3);
    check("learn_ready_in_rst", 64'(bus.learn_ready), 64'(0));
    rst = 1'b0;
    #1;
    check("learn_ready_post_rst", 64'(bus.learn_ready), 64'(1));
    check("rst_match_valid", 64'(bus.match_valid), 64'(0));
    check("rst_match", 64'(bus.match), 64'(0));
    check("rst_match_addr", 64'(bus.match_addr), 64'(0));
    check("rst_learn_done", 64'(bus.learn_done), 64'(0));
    check("rst_learn_addr", 64'(bus.learn_addr), 64'(0));
    check("rst_learn_status", 64'(bus.learn_status), 64'(0));
    check("rst_compare_ready", 64'(bus.compare_ready), 64'(1));
    check("rst_entry_count", 64'(bus.entry_count), 64'(0));

    // Empty-table lookup, then first learn (miss path)
    lookup(K0, 1'b0, '0);
    drain();
    learn(K0, 5'd0, 2'd0);
    check("probe_compare_ready", 64'(bus.compare_ready), 64'(0));
    step();
    check("wait_compare_ready", 64'(bus.compare_ready), 64'(1));
    drain();
    check("learn_ready_after_done", 64'(bus.learn_ready), 64'(1));
    lookup(K0, 1'b1, 5'd0);
    drain();
    check("count_one", 64'(bus.entry_count), 64'(1));

    // Relearn same key: hit path
    learn(K0, 5'd0, 2'd1);
    drain();
    check("count_after_refresh", 64'(bus.entry_count), 64'(1));

    // Fill the table
    for (int i = 1; i < 32; i++) begin
      learn(key(i), 5'(i), 2'd0);
      drain();
    end
    check("count_full", 64'(bus.entry_count), 64'(32));

    // Age everything to 3, refresh entry 7, then evict (entry 0 is oldest, lowest)
    bus.age_tick = 1'b1;
    step(3);
    bus.age_tick = 1'b0;
    lookup(key(7), 1'b1, 5'd7);
    drain();
    learn(KN, 5'd0, 2'd2);
    step(4);
    check("write_compare_ready", 64'(bus.compare_ready), 64'(1));
    lookup(K0, 1'b0, '0);
    lookup(key(5), 1'b1, 5'd5);
    lookup(KN, 1'b0, '0);
    drain();
    check("count_after_evict", 64'(bus.entry_count), 64'(32));
    lookup(KN, 1'b1, 5'd0);
    lookup(key(31), 1'b1, 5'd31);
    drain();

    // Delete in the same cycle as a lookup hit on the same entry
    lookup(key(3), 1'b1, 5'd3);
    step();
    bus.delete_addr  = 5'd3;
    bus.delete_valid = 1'b1;
    step();
    bus.delete_valid = 1'b0;
    lookup(key(3), 1'b0, '0);
    drain();
    check("count_after_delete", 64'(bus.entry_count), 64'(31));

    // Reset in the middle of a write
    bus.learn_data  = KX;
    bus.learn_valid = 1'b1;
    step();
    bus.learn_valid = 1'b0;
    step(8);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    #1;
    check("midrst_learn_ready", 64'(bus.learn_ready), 64'(1));
    check("midrst_learn_done", 64'(bus.learn_done), 64'(0));
    check("midrst_count", 64'(bus.entry_count), 64'(0));
    lookup(KX, 1'b0, '0);
    lookup(key(1), 1'b0, '0);
    drain();

    // Aging: KA expires on the 8th tick, KB refreshed midway survives
    learn(KA, 5'd0, 2'd0);
    drain();
    learn(KB, 5'd1, 2'd0);
    drain();
    bus.age_tick = 1'b1;
    step(4);
    bus.age_tick = 1'b0;
    lookup(KB, 1'b1, 5'd1);
    drain();
    bus.age_tick = 1'b1;
    step(3);
    bus.age_tick = 1'b0;
    check("count_after_7_ticks", 64'(bus.entry_count), 64'(2));
    bus.age_tick = 1'b1;
    step();
    bus.age_tick = 1'b0;
    check("count_after_8_ticks", 64'(bus.entry_count), 64'(1));
    lookup(KA, 1'b0, '0);
    lookup(KB, 1'b1, 5'd1);
    drain();

    step(2);
    check("queues_empty", 64'(mq.size() + lq.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cam_srl_learn.md
# cam_srl_learn

Learning CAM for the L2 switch MAC table: SRL-sliced content-addressable store with per-entry valid and age state, automatic free-slot allocation, LRU-by-age eviction, explicit delete and periodic aging. It sits between the ingress parser and forwarding logic. Lookups are pipelined at one per cycle. Learns are serialized through an internal FSM, so software and forwarding logic never manage addresses directly.

## Interface
- DATA_WIDTH, 48: key width (MAC address); padded internally to a multiple of SLICE_WIDTH.
- ADDR_WIDTH, 5: entries N = 2**ADDR_WIDTH.
- SLICE_WIDTH, 4: key bits per SRL slice; a write occupies W = 2**SLICE_WIDTH cycles.
- AGE_WIDTH, 3: per-entry age counter width; AGE_MAX = 2**AGE_WIDTH-1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- compare_data  in  DATA_WIDTH  lookup key.
- compare_valid  in  1  lookup request; accepted when compare_ready=1.
- compare_ready  out  1  low only in the single cycle the FSM issues its internal probe.
- match_valid  out  1  lookup result strobe, 2 cycles after acceptance.
- match  out  1  at least one valid entry matched.
- match_addr  out  ADDR_WIDTH  lowest matching valid index (0 if no match).
- learn_data  in  DATA_WIDTH  key to learn.
- learn_valid  in  1  learn request.
- learn_ready  out  1  FSM idle and not in reset.
- learn_done  out  1  one-cycle completion pulse.
- learn_addr  out  ADDR_WIDTH  entry used, valid with learn_done.
- learn_status  out  2  with learn_done: 0 new entry, 1 already present (refreshed), 2 evicted a valid entry.
- delete_addr  in  ADDR_WIDTH  entry to invalidate.
- delete_valid  in  1  delete request; always accepted.
- age_tick  in  1  aging pulse.
- entry_count  out  ADDR_WIDTH+1  number of valid entries.

## Operation
- State per entry: key in SRL slices, valid bit, age counter. Raw slice matches are ANDed across slices, then masked by valid.
- Lookup: 2-stage pipeline, one per cycle, and runs during writes. A lookup hit sets age[match_addr]=0 in the match_valid cycle. Only the reported lowest index is refreshed.
- Learn FSM states: IDLE -> PROBE -> WAIT (2 cycles) -> WRITE (W cycles, on a miss) -> DONE -> IDLE.
  - PROBE: issues learn_data into the lookup pipeline; compare_ready=0; the probe does not produce match_valid.
  - End of WAIT, hit: age of hit entry = 0; status 1; go to DONE.
  - End of WAIT, miss, a free entry exists: target = lowest-index invalid entry; status 0.
  - End of WAIT, miss, table full: target = highest-age entry (lowest index on tie); status 2.
  - WRITE: target valid cleared in the first WRITE cycle, so there are no partial matches while writing.
  - DONE: target valid=1, age=0; learn_done pulses.
- Delete: valid[delete_addr]=0 next cycle. A delete of the current WRITE target leaves it invalid at DONE; learn still reports completion.
- Aging on age_tick, applied to each valid entry:
  - age==AGE_MAX -> valid=0.
  - otherwise age+1.
- Priority per entry, same cycle: delete > refresh/DONE-set > age_tick.
- entry_count = popcount(valid), registered.

## Timing
- Reset values:
  - all valid=0 and age=0; entry_count=0.
  - match_valid, match, match_addr, learn_done, learn_addr and learn_status are all 0.
  - learn_ready=0 while rst is high, 1 in the first cycle after.
  - compare_ready=1.
- Reset mid-learn: the FSM aborts to IDLE; the partially written entry stays invalid.
- Lookup accepted in cycle T -> match_valid in T+2.
- Learn accepted in cycle T (learn_valid & learn_ready):
  - PROBE at T+1 (compare_ready=0).
  - Hit: learn_done at T+4.
  - Miss: WRITE in T+4..T+3+W; learn_done at T+4+W.
  - learn_ready is high again at learn_done+1.
- A lookup accepted in or after the learn_done cycle sees the new entry.
- Delete or age_tick in cycle T takes effect from T+1. A lookup accepted at T+1 sees the updated valid bits.

## Test plan
- Reset, then lookup key 0x001122334455 -> match_valid at T+2 with match=0; entry_count=0.
- Learn 0x001122334455 -> learn_done at T+4+16 (SLICE_WIDTH=4), learn_addr=0, status 0. A following lookup -> match=1, match_addr=0.
- Learn the same key again -> learn_done at T+4, status 1, entry_count unchanged at 1.
- Fill all 32 entries, tick age 3 times, lookup entry 7 (refresh), then learn a new key -> status 2, learn_addr=0 (lowest index among maximum age).
- Learn an entry, then apply 8 age_ticks (AGE_MAX=7) -> the lookup after the 8th tick gives match=0 and entry_count decrements.
- Delete an entry in the same cycle as a lookup hit on it -> valid=0. A lookup at T+1 misses. During an ongoing WRITE, external lookups still return correct results for other entries, with compare_ready=0 only in the PROBE cycle.
